// File: rtl/axi4_lite_regfile_if.sv
// AXI4-Lite bus bundle between an interconnect master and the register bank.
interface axi4_lite_regfile_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned STRB_W = DATA_W / 8;

    logic              AWVALID;
    logic              AWREADY;
    logic [ADDR_W-1:0] AWADDR;
    logic              WVALID;
    logic              WREADY;
    logic [DATA_W-1:0] WDATA;
    logic [STRB_W-1:0] WSTRB;
    logic              BVALID;
    logic              BREADY;
    logic [1:0]        BRESP;
    logic              ARVALID;
    logic              ARREADY;
    logic [ADDR_W-1:0] ARADDR;
    logic              RVALID;
    logic              RREADY;
    logic [DATA_W-1:0] RDATA;
    logic [1:0]        RRESP;

    modport master (
        output AWVALID, AWADDR, WVALID, WDATA, WSTRB, BREADY, ARVALID, ARADDR, RREADY,
        input  AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
    );

    modport slave (
        input  AWVALID, AWADDR, WVALID, WDATA, WSTRB, BREADY, ARVALID, ARADDR, RREADY,
        output AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
    );
endinterface

// File: rtl/axi4_lite_regfile.sv
// AXI4-Lite slave register bank: REG_COUNT words, byte-strobe writes,
// per-register read-only selection, OKAY/SLVERR/DECERR responses.
// Write and read channels run independent FSMs; AW and W may arrive in any order.
module axi4_lite_regfile #(
    parameter int unsigned          ADDR_W    = 32,
    parameter int unsigned          DATA_W    = 32,
    parameter int unsigned          REG_COUNT = 16,
    parameter logic [REG_COUNT-1:0] RO_MASK   = '0
) (
    input  logic                        ACLK,
    input  logic                        ARESET,
    axi4_lite_regfile_if.slave          axi,
    output logic [REG_COUNT*DATA_W-1:0] regs_out,
    input  logic [REG_COUNT*DATA_W-1:0] regs_in,
    output logic [REG_COUNT-1:0]        wr_pulse
);
    localparam int unsigned STRB_W  = DATA_W / 8;
    localparam int unsigned LSB     = $clog2(STRB_W);
    localparam int unsigned IDX_W   = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;
    localparam int unsigned UPPER_W = ADDR_W - LSB;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        W_COLLECT,
        W_EXEC,
        W_RESP
    } wstate_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_EXEC,
        R_RESP
    } rstate_t;

    wstate_t w_state;
    rstate_t r_state;

    // Only the word-addressing bits are captured; byte-offset bits are ignored.
    logic                        aw_held;
    logic                        w_held;
    logic [UPPER_W-1:0]          aw_addr_q;
    logic [DATA_W-1:0]           w_data_q;
    logic [STRB_W-1:0]           w_strb_q;
    logic [UPPER_W-1:0]          ar_addr_q;
    logic [REG_COUNT*DATA_W-1:0] regs_q;

    logic             aw_hs_c;
    logic             w_hs_c;
    logic             ar_hs_c;
    logic [IDX_W-1:0] aw_idx_c;
    logic [IDX_W-1:0] ar_idx_c;
    logic             aw_ok_c;
    logic             ar_ok_c;
    logic             unused_addr_lsbs;

    // Word index must be below REG_COUNT and no address bit above the index may be set.
    function automatic logic addr_in_range(input logic [UPPER_W-1:0] a);
        return ((a >> IDX_W) == '0) && (32'(a[IDX_W-1:0]) < REG_COUNT);
    endfunction

    assign aw_hs_c  = axi.AWVALID && axi.AWREADY;
    assign w_hs_c   = axi.WVALID && axi.WREADY;
    assign ar_hs_c  = axi.ARVALID && axi.ARREADY;
    assign aw_idx_c = aw_addr_q[IDX_W-1:0];
    assign ar_idx_c = ar_addr_q[IDX_W-1:0];
    assign aw_ok_c  = addr_in_range(aw_addr_q);
    assign ar_ok_c  = addr_in_range(ar_addr_q);
    assign regs_out = regs_q;

    assign unused_addr_lsbs = ^{axi.AWADDR[LSB-1:0], axi.ARADDR[LSB-1:0]};

    // Write channel: collect AW and W in any order, execute once, hold B until accepted.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            w_state     <= W_COLLECT;
            aw_held     <= 1'b0;
            w_held      <= 1'b0;
            aw_addr_q   <= '0;
            w_data_q    <= '0;
            w_strb_q    <= '0;
            regs_q      <= '0;
            wr_pulse    <= '0;
            axi.AWREADY <= 1'b0;
            axi.WREADY  <= 1'b0;
            axi.BVALID  <= 1'b0;
            axi.BRESP   <= RESP_OKAY;
        end else begin
            wr_pulse <= '0;
            case (w_state)
                W_COLLECT: begin
                    if (aw_hs_c) begin
                        aw_addr_q <= axi.AWADDR[ADDR_W-1:LSB];
                        aw_held   <= 1'b1;
                    end
                    if (w_hs_c) begin
                        w_data_q <= axi.WDATA;
                        w_strb_q <= axi.WSTRB;
                        w_held   <= 1'b1;
                    end
                    if ((aw_held || aw_hs_c) && (w_held || w_hs_c)) begin
                        axi.AWREADY <= 1'b0;
                        axi.WREADY  <= 1'b0;
                        w_state     <= W_EXEC;
                    end else begin
                        axi.AWREADY <= !(aw_held || aw_hs_c);
                        axi.WREADY  <= !(w_held || w_hs_c);
                    end
                end
                W_EXEC: begin
                    aw_held <= 1'b0;
                    w_held  <= 1'b0;
                    if (!aw_ok_c) begin
                        axi.BRESP <= RESP_DECERR;
                    end else if (RO_MASK[aw_idx_c]) begin
                        axi.BRESP <= RESP_SLVERR;
                    end else begin
                        for (int b = 0; b < STRB_W; b++) begin
                            if (w_strb_q[b]) begin
                                regs_q[32'(aw_idx_c) * DATA_W + 32'(b) * 8 +: 8] <= w_data_q[b*8 +: 8];
                            end
                        end
                        wr_pulse[aw_idx_c] <= 1'b1;
                        axi.BRESP          <= RESP_OKAY;
                    end
                    w_state <= W_RESP;
                end
                W_RESP: begin
                    if (!axi.BVALID) begin
                        axi.BVALID <= 1'b1;
                    end else if (axi.BREADY) begin
                        axi.BVALID <= 1'b0;
                        w_state    <= W_COLLECT;
                    end
                end
                default: begin
                    w_state <= W_COLLECT;
                end
            endcase
        end
    end

    // Read channel: accept one address, sample the bank, hold R until accepted.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state     <= R_IDLE;
            ar_addr_q   <= '0;
            axi.ARREADY <= 1'b0;
            axi.RVALID  <= 1'b0;
            axi.RDATA   <= '0;
            axi.RRESP   <= RESP_OKAY;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (ar_hs_c) begin
                        ar_addr_q   <= axi.ARADDR[ADDR_W-1:LSB];
                        axi.ARREADY <= 1'b0;
                        r_state     <= R_EXEC;
                    end else begin
                        axi.ARREADY <= 1'b1;
                    end
                end
                R_EXEC: begin
                    // Samples regs_q before any same-cycle write lands.
                    if (!ar_ok_c) begin
                        axi.RDATA <= '0;
                        axi.RRESP <= RESP_DECERR;
                    end else if (RO_MASK[ar_idx_c]) begin
                        axi.RDATA <= regs_in[32'(ar_idx_c) * DATA_W +: DATA_W];
                        axi.RRESP <= RESP_OKAY;
                    end else begin
                        axi.RDATA <= regs_q[32'(ar_idx_c) * DATA_W +: DATA_W];
                        axi.RRESP <= RESP_OKAY;
                    end
                    r_state <= R_RESP;
                end
                R_RESP: begin
                    if (!axi.RVALID) begin
                        axi.RVALID <= 1'b1;
                    end else if (axi.RREADY) begin
                        axi.RVALID <= 1'b0;
                        r_state    <= R_IDLE;
                    end
                end
                default: begin
                    r_state <= R_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_axi4_lite_regfile.sv
// Bench for axi4_lite_regfile: directed scenarios plus randomized traffic
// compared against an array-based model of the register bank.
`timescale 1ns/1ps
module tb_axi4_lite_regfile;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned NREG   = 16;
    localparam logic [NREG-1:0] RO = 16'h0008;

    logic                   ACLK = 1'b0;
    logic                   ARESET;
    logic [NREG*DATA_W-1:0] regs_out;
    logic [NREG*DATA_W-1:0] regs_in;
    logic [NREG-1:0]        wr_pulse;

    axi4_lite_regfile_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    axi4_lite_regfile #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .REG_COUNT(NREG), .RO_MASK(RO)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET), .axi(bus),
        .regs_out(regs_out), .regs_in(regs_in), .wr_pulse(wr_pulse)
    );

    always #5 ACLK = ~ACLK;

    int total = 0;
    int bad   = 0;
    logic [31:0] model [NREG];

    // ---- reference model ----
    function automatic logic [1:0] exp_wresp(input logic [31:0] addr);
        int unsigned idx = addr >> 2;
        if (idx >= NREG) return 2'b11;
        if (RO[idx]) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [31:0] exp_rdata(input logic [31:0] addr);
        int unsigned idx = addr >> 2;
        if (idx >= NREG) return 32'h0;
        if (RO[idx]) return regs_in[idx*32 +: 32];
        return model[idx];
    endfunction

    function automatic logic [1:0] exp_rresp(input logic [31:0] addr);
        int unsigned idx = addr >> 2;
        return (idx >= NREG) ? 2'b11 : 2'b00;
    endfunction

    function automatic void model_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int unsigned idx = addr >> 2;
        if (exp_wresp(addr) != 2'b00) return;
        for (int b = 0; b < 4; b++)
            if (strb[b]) model[idx][b*8 +: 8] = data[b*8 +: 8];
    endfunction

    function automatic logic [NREG*DATA_W-1:0] model_packed();
        logic [NREG*DATA_W-1:0] p;
        for (int i = 0; i < NREG; i++) p[i*32 +: 32] = model[i];
        return p;
    endfunction

    function automatic logic [31:0] rout(input int i);
        return regs_out[i*32 +: 32];
    endfunction

    // ---- bus drivers ----
    task automatic send_aw_w(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int w_lead, output bit tmo, output bit ready_stuck);
        int aw_at, w_at, cyc;
        bit aw_done, w_done, aw_fire, w_fire;
        aw_at = (w_lead > 0) ? w_lead : 0;
        w_at  = (w_lead < 0) ? -w_lead : 0;
        aw_done = 0; w_done = 0; cyc = 0; ready_stuck = 0;
        while (!(aw_done && w_done) && cyc < 50) begin
            if (cyc == aw_at && !aw_done) begin bus.AWVALID = 1'b1; bus.AWADDR = addr; end
            if (cyc == w_at && !w_done) begin bus.WVALID = 1'b1; bus.WDATA = data; bus.WSTRB = strb; end
            aw_fire = bus.AWVALID && bus.AWREADY;
            w_fire  = bus.WVALID && bus.WREADY;
            @(posedge ACLK); #1;
            if (aw_fire) begin bus.AWVALID = 1'b0; aw_done = 1; end
            if (w_fire)  begin bus.WVALID  = 1'b0; w_done  = 1; end
            if (!(aw_done && w_done) && ((aw_done && bus.AWREADY) || (w_done && bus.WREADY)))
                ready_stuck = 1;
            cyc++;
        end
        tmo = !(aw_done && w_done);
        bus.AWVALID = 1'b0;
        bus.WVALID  = 1'b0;
    endtask

    task automatic wait_b(output int lat, output logic [15:0] pulse1, output int pcyc, output bit tmo);
        lat = 0; pcyc = 0; pulse1 = '0;
        while (!bus.BVALID && lat < 20) begin
            @(posedge ACLK); #1;
            lat++;
            if (lat == 1) pulse1 = wr_pulse;
            if (wr_pulse != '0) pcyc++;
        end
        tmo = !bus.BVALID;
    endtask

    task automatic accept_b(output logic [1:0] resp);
        resp = bus.BRESP;
        bus.BREADY = 1'b1;
        @(posedge ACLK); #1;
        bus.BREADY = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int w_lead, output logic [1:0] resp, output int lat,
                            output logic [15:0] pulse1, output int pcyc, output bit tmo, output bit stuck);
        bit t1, t2;
        send_aw_w(addr, data, strb, w_lead, t1, stuck);
        wait_b(lat, pulse1, pcyc, t2);
        accept_b(resp);
        tmo = t1 || t2;
    endtask

    task automatic do_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp,
                           output int lat, output bit tmo);
        int cyc;
        bit fired;
        cyc = 0; fired = 0;
        bus.ARVALID = 1'b1;
        bus.ARADDR  = addr;
        while (!fired && cyc < 50) begin
            fired = bus.ARREADY;
            @(posedge ACLK); #1;
            cyc++;
        end
        bus.ARVALID = 1'b0;
        lat = 0;
        while (fired && !bus.RVALID && lat < 20) begin
            @(posedge ACLK); #1;
            lat++;
        end
        tmo  = !fired || !bus.RVALID;
        data = bus.RDATA;
        resp = bus.RRESP;
        bus.RREADY = 1'b1;
        @(posedge ACLK); #1;
        bus.RREADY = 1'b0;
    endtask

    // ---- scenarios ----
    task automatic test_reset();
        bus.AWVALID = 0; bus.AWADDR = '0; bus.WVALID = 0; bus.WDATA = '0; bus.WSTRB = '0;
        bus.BREADY = 0; bus.ARVALID = 0; bus.ARADDR = '0; bus.RREADY = 0;
        for (int i = 0; i < NREG; i++) begin
            model[i] = '0;
            regs_in[i*32 +: 32] = $urandom;
        end
        regs_in[3*32 +: 32] = 32'hCAFE0000;
        ARESET = 1'b1;
        repeat (3) @(posedge ACLK);
        #1;
        total++; if ({bus.AWREADY, bus.WREADY, bus.ARREADY, bus.BVALID, bus.RVALID} !== 5'b0) begin
            bad++; $display("FAIL reset_ctrl got=%b exp=00000", {bus.AWREADY, bus.WREADY, bus.ARREADY, bus.BVALID, bus.RVALID}); end
        total++; if ({bus.BRESP, bus.RRESP, bus.RDATA} !== 36'h0) begin
            bad++; $display("FAIL reset_resp got=%h exp=0", {bus.BRESP, bus.RRESP, bus.RDATA}); end
        total++; if (regs_out !== '0 || wr_pulse !== '0) begin
            bad++; $display("FAIL reset_regs regs_or=%b pulse=%h exp=0", |regs_out, wr_pulse); end
        ARESET = 1'b0;
        total++; if ({bus.AWREADY, bus.WREADY, bus.ARREADY} !== 3'b000) begin
            bad++; $display("FAIL ready_before_edge got=%b exp=000", {bus.AWREADY, bus.WREADY, bus.ARREADY}); end
        @(posedge ACLK); #1;
        total++; if ({bus.AWREADY, bus.WREADY, bus.ARREADY} !== 3'b111) begin
            bad++; $display("FAIL ready_after_edge got=%b exp=111", {bus.AWREADY, bus.WREADY, bus.ARREADY}); end
    endtask

    task automatic test_basic();
        logic [1:0] resp; int lat; logic [15:0] p1; int pc; bit tmo, stuck; logic [31:0] d;
        do_write(32'h8, 32'hDEADBEEF, 4'hF, 0, resp, lat, p1, pc, tmo, stuck);
        model_write(32'h8, 32'hDEADBEEF, 4'hF);
        total++; if (tmo || lat != 2) begin bad++; $display("FAIL basic_b_latency got=%0d tmo=%0d exp=2", lat, tmo); end
        total++; if (resp !== 2'b00) begin bad++; $display("FAIL basic_bresp got=%b exp=00", resp); end
        total++; if (p1 !== 16'h0004 || pc != 1) begin bad++; $display("FAIL basic_pulse got=%h cycles=%0d exp=0004 cycles=1", p1, pc); end
        total++; if (rout(2) !== model[2]) begin bad++; $display("FAIL basic_regs_out got=%h exp=%h", rout(2), model[2]); end
        do_read(32'h8, d, resp, lat, tmo);
        total++; if (tmo || lat != 2) begin bad++; $display("FAIL basic_r_latency got=%0d tmo=%0d exp=2", lat, tmo); end
        total++; if (d !== exp_rdata(32'h8) || resp !== 2'b00) begin
            bad++; $display("FAIL basic_read got=%h/%b exp=%h/00", d, resp, exp_rdata(32'h8)); end
    endtask

    task automatic test_w_before_aw();
        logic [1:0] resp; int lat; logic [15:0] p1; int pc; bit tmo, stuck;
        do_write(32'h4, 32'hFFFFFFFF, 4'hF, 0, resp, lat, p1, pc, tmo, stuck);
        model_write(32'h4, 32'hFFFFFFFF, 4'hF);
        do_write(32'h4, 32'h11223344, 4'b0101, 3, resp, lat, p1, pc, tmo, stuck);
        model_write(32'h4, 32'h11223344, 4'b0101);
        total++; if (tmo || stuck) begin bad++; $display("FAIL wfirst_ready_drop tmo=%0d ready_high_after_capture=%0d exp=0", tmo, stuck); end
        total++; if (resp !== 2'b00) begin bad++; $display("FAIL wfirst_bresp got=%b exp=00", resp); end
        total++; if (rout(1) !== model[1]) begin bad++; $display("FAIL wfirst_merge got=%h exp=%h", rout(1), model[1]); end
    endtask

    task automatic test_read_only();
        logic [1:0] resp; int lat; logic [15:0] p1; int pc; bit tmo, stuck; logic [31:0] d;
        do_write(32'hC, 32'h12345678, 4'hF, -1, resp, lat, p1, pc, tmo, stuck);
        total++; if (tmo || resp !== exp_wresp(32'hC)) begin bad++; $display("FAIL ro_bresp got=%b exp=%b", resp, exp_wresp(32'hC)); end
        total++; if (pc != 0 || rout(3) !== model[3]) begin bad++; $display("FAIL ro_nochange pulses=%0d reg=%h exp=0/%h", pc, rout(3), model[3]); end
        do_read(32'hC, d, resp, lat, tmo);
        total++; if (tmo || d !== exp_rdata(32'hC) || resp !== 2'b00) begin
            bad++; $display("FAIL ro_read got=%h/%b exp=%h/00", d, resp, exp_rdata(32'hC)); end
    endtask

    task automatic test_decode();
        logic [1:0] resp; int lat; logic [15:0] p1; int pc; bit tmo, stuck; logic [31:0] d;
        logic [NREG*DATA_W-1:0] snap;
        snap = model_packed();
        do_write(32'h40, 32'hA5A5A5A5, 4'hF, 0, resp, lat, p1, pc, tmo, stuck);
        total++; if (tmo || resp !== exp_wresp(32'h40) || pc != 0) begin
            bad++; $display("FAIL dec_write got=%b pulses=%0d exp=%b/0", resp, pc, exp_wresp(32'h40)); end
        do_write(32'h1004, 32'h5A5A5A5A, 4'hF, 1, resp, lat, p1, pc, tmo, stuck);
        total++; if (tmo || resp !== exp_wresp(32'h1004)) begin bad++; $display("FAIL dec_high_write got=%b exp=%b", resp, exp_wresp(32'h1004)); end
        total++; if (regs_out !== snap) begin bad++; $display("FAIL dec_nochange regs_out differs from model"); end
        do_read(32'h40, d, resp, lat, tmo);
        total++; if (tmo || d !== exp_rdata(32'h40) || resp !== exp_rresp(32'h40)) begin
            bad++; $display("FAIL dec_read got=%h/%b exp=0/11", d, resp); end
        do_read(32'h80000008, d, resp, lat, tmo);
        total++; if (tmo || d !== exp_rdata(32'h80000008) || resp !== exp_rresp(32'h80000008)) begin
            bad++; $display("FAIL dec_high_read got=%h/%b exp=0/11", d, resp); end
        do_read(32'h9, d, resp, lat, tmo);
        total++; if (tmo || d !== exp_rdata(32'h9) || resp !== 2'b00) begin
            bad++; $display("FAIL dec_low_bits got=%h/%b exp=%h/00", d, resp, exp_rdata(32'h9)); end
    endtask

    task automatic test_strobe_zero();
        logic [1:0] resp; int lat; logic [15:0] p1; int pc; bit tmo, stuck;
        do_write(32'h14, $urandom, 4'h0, 0, resp, lat, p1, pc, tmo, stuck);
        total++; if (tmo || resp !== 2'b00 || p1 !== 16'h0020) begin
            bad++; $display("FAIL strb0 resp=%b pulse=%h exp=00/0020", resp, p1); end
        total++; if (rout(5) !== model[5]) begin bad++; $display("FAIL strb0_nochange got=%h exp=%h", rout(5), model[5]); end
    endtask

    task automatic test_random();
        logic [1:0] resp; int lat; logic [15:0] p1, ep; int pc; bit tmo, stuck;
        logic [31:0] addr, data, d; logic [3:0] strb; int lead;
        for (int n = 0; n < 40; n++) begin
            addr = ($urandom_range(0, 19) << 2) | $urandom_range(0, 3);
            if ($urandom_range(0, 7) == 0) addr = addr | (32'h1 << $urandom_range(6, 31));
            if ($urandom_range(0, 1) == 0) begin
                data = $urandom; strb = 4'($urandom); lead = int'($urandom_range(0, 6)) - 3;
                do_write(addr, data, strb, lead, resp, lat, p1, pc, tmo, stuck);
                ep = '0;
                if (exp_wresp(addr) == 2'b00) ep[addr >> 2] = 1'b1;
                total++; if (tmo || resp !== exp_wresp(addr) || p1 !== ep || lat != 2) begin
                    bad++; $display("FAIL rnd_write[%0d] a=%h resp=%b pulse=%h lat=%0d exp=%b/%h/2", n, addr, resp, p1, lat, exp_wresp(addr), ep); end
                model_write(addr, data, strb);
                total++; if (regs_out !== model_packed()) begin
                    bad++; $display("FAIL rnd_regs[%0d] a=%h regs_out differs from model", n, addr); end
            end else begin
                do_read(addr, d, resp, lat, tmo);
                total++; if (tmo || d !== exp_rdata(addr) || resp !== exp_rresp(addr)) begin
                    bad++; $display("FAIL rnd_read[%0d] a=%h got=%h/%b exp=%h/%b", n, addr, d, resp, exp_rdata(addr), exp_rresp(addr)); end
            end
        end
    endtask

    task automatic test_collision();
        logic [31:0] old, nv; int cyc; bit ok;
        old = model[6];
        nv  = $urandom;
        cyc = 0;
        while (!(bus.AWREADY && bus.WREADY && bus.ARREADY) && cyc < 10) begin @(posedge ACLK); #1; cyc++; end
        bus.AWVALID = 1; bus.AWADDR = 32'h18; bus.WVALID = 1; bus.WDATA = nv; bus.WSTRB = 4'hF;
        bus.ARVALID = 1; bus.ARADDR = 32'h18;
        ok = bus.AWREADY && bus.WREADY && bus.ARREADY;
        @(posedge ACLK); #1;
        bus.AWVALID = 0; bus.WVALID = 0; bus.ARVALID = 0;
        model_write(32'h18, nv, 4'hF);
        cyc = 0;
        while (!(bus.BVALID && bus.RVALID) && cyc < 10) begin @(posedge ACLK); #1; cyc++; end
        total++; if (!ok || !(bus.BVALID && bus.RVALID) || bus.RDATA !== old || bus.RRESP !== 2'b00) begin
            bad++; $display("FAIL collision_read got=%h/%b exp=%h/00 (hs=%0d)", bus.RDATA, bus.RRESP, old, ok); end
        total++; if (rout(6) !== model[6] || bus.BRESP !== 2'b00) begin
            bad++; $display("FAIL collision_write got=%h/%b exp=%h/00", rout(6), bus.BRESP, model[6]); end
        bus.BREADY = 1; bus.RREADY = 1;
        @(posedge ACLK); #1;
        bus.BREADY = 0; bus.RREADY = 0;
    endtask

    task automatic test_back_pressure();
        logic [1:0] resp, r0, rr; int lat; logic [15:0] p1; int pc; bit tmo, stuck, stable;
        logic [31:0] d;
        send_aw_w(32'h1C, 32'h0BADF00D, 4'hF, 0, tmo, stuck);
        model_write(32'h1C, 32'h0BADF00D, 4'hF);
        wait_b(lat, p1, pc, tmo);
        r0 = bus.BRESP;
        stable = !tmo;
        for (int i = 0; i < 10; i++) begin
            @(posedge ACLK); #1;
            if (bus.BVALID !== 1'b1 || bus.BRESP !== r0 || bus.AWREADY !== 1'b0 || bus.WREADY !== 1'b0) stable = 0;
        end
        total++; if (!stable || r0 !== 2'b00) begin bad++; $display("FAIL bp_stall_stable stable=%0d bresp=%b exp=1/00", stable, r0); end
        do_read(32'h8, d, rr, lat, tmo);
        total++; if (tmo || d !== exp_rdata(32'h8) || rr !== 2'b00) begin
            bad++; $display("FAIL bp_read got=%h/%b exp=%h/00", d, rr, exp_rdata(32'h8)); end
        do_read(32'h1C, d, rr, lat, tmo);
        total++; if (tmo || d !== exp_rdata(32'h1C)) begin bad++; $display("FAIL bp_read_new got=%h exp=%h", d, exp_rdata(32'h1C)); end
        total++; if (bus.BVALID !== 1'b1 || bus.BRESP !== r0) begin
            bad++; $display("FAIL bp_b_held got=%b/%b exp=1/%b", bus.BVALID, bus.BRESP, r0); end
        accept_b(resp);
        total++; if (bus.BVALID !== 1'b0) begin bad++; $display("FAIL bp_b_release got=%b exp=0", bus.BVALID); end
    endtask

    task automatic test_reset_mid();
        int lat; logic [15:0] p1; int pc; bit tmo, stuck; logic [31:0] d; logic [1:0] rr;
        send_aw_w(32'h24, 32'h13572468, 4'hF, 0, tmo, stuck);
        wait_b(lat, p1, pc, tmo);
        total++; if (tmo || bus.BVALID !== 1'b1) begin bad++; $display("FAIL rstmid_pending got=%b exp=1", bus.BVALID); end
        #2;
        ARESET = 1'b1;
        #1;
        total++; if (bus.BVALID !== 1'b0 || bus.RVALID !== 1'b0) begin
            bad++; $display("FAIL rstmid_async_valid got=%b%b exp=00", bus.BVALID, bus.RVALID); end
        total++; if (regs_out !== '0 || wr_pulse !== '0) begin bad++; $display("FAIL rstmid_regs_clear got_nonzero=%b exp=0", |regs_out); end
        for (int i = 0; i < NREG; i++) model[i] = '0;
        @(posedge ACLK); @(posedge ACLK); #1;
        ARESET = 1'b0;
        total++; if ({bus.AWREADY, bus.WREADY, bus.ARREADY} !== 3'b000) begin
            bad++; $display("FAIL rstmid_ready_low got=%b exp=000", {bus.AWREADY, bus.WREADY, bus.ARREADY}); end
        @(posedge ACLK); #1;
        total++; if ({bus.AWREADY, bus.WREADY, bus.ARREADY} !== 3'b111) begin
            bad++; $display("FAIL rstmid_ready_back got=%b exp=111", {bus.AWREADY, bus.WREADY, bus.ARREADY}); end
        do_read(32'h8, d, rr, lat, tmo);
        total++; if (tmo || d !== exp_rdata(32'h8) || rr !== 2'b00) begin
            bad++; $display("FAIL rstmid_read got=%h/%b exp=%h/00", d, rr, exp_rdata(32'h8)); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_w_before_aw();
        test_read_only();
        test_decode();
        test_strobe_zero();
        test_random();
        test_collision();
        test_back_pressure();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule
